// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the memory port arbiter
// DMType codes, FSM states and requester ids used by the arbiter and its lane aligner.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    dm_word              = 3'd0,
    dm_halfword          = 3'd1,
    dm_halfword_unsigned = 3'd2,
    dm_byte              = 3'd3,
    dm_byte_unsigned     = 3'd4
  } dm_type_e;

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_busy = 2'd1,
    st_resp = 2'd2
  } arb_state_e;

  typedef enum logic {
    req_if = 1'b0,
    req_d  = 1'b1
  } req_id_e;

  localparam logic [3:0] BE_ALL = 4'b1111;

  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle
// master is the arbiter's view; slave is the pipeline/memory environment's view.
interface mem_port_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_stall;

  logic        d_req;
  logic        d_we;
  logic [2:0]  d_type;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_stall;

  logic        misalign_err;
  logic        bus_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_type, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall, misalign_err, bus_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_type, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, if_stall, d_rdata, d_ack, d_stall, misalign_err, bus_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering and load extension for one access
// Purely combinational; unknown type codes behave as a full word.
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0]  dm_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    be         = BE_ALL;
    wdata_out  = wdata;
    rdata_ext  = rdata;
    misaligned = (addr_lo != 2'b00);

    case (addr_lo)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (dm_type)
      dm_byte: begin
        be         = 4'b0001 << addr_lo;
        wdata_out  = {4{wdata[7:0]}};
        misaligned = 1'b0;
        rdata_ext  = {{24{byte_lane[7]}}, byte_lane};
      end
      dm_byte_unsigned: begin
        be         = 4'b0001 << addr_lo;
        wdata_out  = {4{wdata[7:0]}};
        misaligned = 1'b0;
        rdata_ext  = {24'b0, byte_lane};
      end
      dm_halfword: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_out  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
        rdata_ext  = {{16{half_lane[15]}}, half_lane};
      end
      dm_halfword_unsigned: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_out  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
        rdata_ext  = {16'b0, half_lane};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and MEM stage
// IDLE grants and latches a request, BUSY runs the memory handshake, RESP pulses the ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 255,
  parameter bit          DATA_PRIO = 1'b1
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);

  localparam int unsigned      CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  arb_state_e       state_q, state_d;
  req_id_e          gnt_q, gnt_d;
  req_id_e          last_grant_q, last_grant_d;
  req_id_e          sel;
  logic             we_q, we_d;
  logic [2:0]       type_q, type_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             mis_q, mis_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  logic [2:0]  la_type;
  logic [1:0]  la_addr;
  logic [3:0]  la_be;
  logic [31:0] la_wdata;
  logic [31:0] la_rdata;
  logic        la_mis;

  logic        mem_req_c;
  logic        mem_we_c;
  logic [31:0] mem_addr_c;
  logic [3:0]  mem_be_c;
  logic [31:0] mem_wdata_c;
  logic        resp;

  // Both strategies end up favouring whoever did not win last time when both are waiting.
  always_comb begin
    sel = req_if;
    if (bus.if_req && bus.d_req) begin
      if (DATA_PRIO) sel = (last_grant_q == req_d) ? req_if : req_d;
      else           sel = (last_grant_q == req_if) ? req_d : req_if;
    end else if (bus.d_req) begin
      sel = req_d;
    end
  end

  // The aligner looks at the incoming request in IDLE (for the misalign check) and at the latched one otherwise.
  always_comb begin
    if (state_q == st_idle) begin
      la_type = (sel == req_d) ? bus.d_type : dm_word;
      la_addr = (sel == req_d) ? bus.d_addr[1:0] : bus.if_addr[1:0];
    end else begin
      la_type = type_q;
      la_addr = addr_q[1:0];
    end
  end

  mem_lane_align u_lane_align (
    .dm_type   (la_type),
    .addr_lo   (la_addr),
    .wdata     (wdata_q),
    .rdata     (bus.mem_rdata),
    .be        (la_be),
    .wdata_out (la_wdata),
    .rdata_ext (la_rdata),
    .misaligned(la_mis)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    type_d       = type_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    mis_d        = mis_q;
    bus_err_d    = bus_err_q;
    cnt_d        = cnt_q;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    mem_addr_c   = '0;
    mem_be_c     = '0;
    mem_wdata_c  = '0;

    case (state_q)
      st_idle: begin
        if (bus.if_req || bus.d_req) begin
          gnt_d        = sel;
          last_grant_d = sel;
          we_d         = (sel == req_d) ? bus.d_we : 1'b0;
          type_d       = la_type;
          addr_d       = (sel == req_d) ? bus.d_addr : bus.if_addr;
          wdata_d      = (sel == req_d) ? bus.d_wdata : '0;
          rdata_d      = '0;
          bus_err_d    = 1'b0;
          mis_d        = la_mis;
          cnt_d        = '0;
          state_d      = la_mis ? st_resp : st_busy;
        end
      end
      st_busy: begin
        mem_req_c   = 1'b1;
        mem_we_c    = we_q;
        mem_addr_c  = word_addr(addr_q);
        mem_be_c    = we_q ? la_be : BE_ALL;
        mem_wdata_c = we_q ? la_wdata : '0;
        if (bus.mem_ready) begin
          rdata_d = la_rdata;
          state_d = st_resp;
        end else if ((TIMEOUT != 0) && (cnt_inc == CNT_LIMIT)) begin
          rdata_d   = '0;
          bus_err_d = 1'b1;
          state_d   = st_resp;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      st_resp: begin
        state_d = st_idle;
      end
      default: begin
        state_d = st_idle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= st_idle;
      gnt_q        <= req_if;
      last_grant_q <= req_if;
      we_q         <= 1'b0;
      type_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      mis_q        <= 1'b0;
      bus_err_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      type_q       <= type_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      mis_q        <= mis_d;
      bus_err_q    <= bus_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign resp = (state_q == st_resp);

  assign bus.if_ack       = resp && (gnt_q == req_if);
  assign bus.d_ack        = resp && (gnt_q == req_d);
  assign bus.if_rdata     = bus.if_ack ? rdata_q : '0;
  assign bus.d_rdata      = bus.d_ack ? rdata_q : '0;
  assign bus.misalign_err = resp && mis_q;
  assign bus.bus_err      = resp && bus_err_q;
  assign bus.if_stall     = bus.if_req & ~bus.if_ack;
  assign bus.d_stall      = bus.d_req & ~bus.d_ack;

  assign bus.mem_req   = mem_req_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_be    = mem_be_c;
  assign bus.mem_wdata = mem_wdata_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
// Byte-array reference memory predicts every ack; a monitor pops per-requester queues.
module tb_mem_port_arbiter;

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        mis;
    logic        bus;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus_if ();

  mem_port_arbiter #(.TIMEOUT(4), .DATA_PRIO(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] mem_words [1024];
  logic [7:0]  ref_bytes [4096];
  int          max_wait = 0;
  bit          stuck    = 1'b0;
  int          wait_cnt = 0;
  exp_t        if_q[$];
  exp_t        d_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    mem_words[a[11:2]] = w;
    for (int k = 0; k < 4; k++) ref_bytes[{a[11:2], 2'b00} + k] = w[8*k +: 8];
  endtask

  function automatic logic [31:0] ref_read(input logic [11:0] a, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[a + i]) << (8 * i));
    return v;
  endfunction

  task automatic model_data(input logic we, input logic [2:0] t, input logic [31:0] a,
                            input logic [31:0] wd, output exp_t e);
    int n;
    logic m;
    logic [31:0] v;
    case (t)
      3'd3, 3'd4: begin n = 1; m = 1'b0;          end
      3'd1, 3'd2: begin n = 2; m = a[0];          end
      default:    begin n = 4; m = (a[1:0] != 0); end
    endcase
    e.rdata = '0; e.chk_rdata = 1'b1; e.mis = m; e.bus = 1'b0;
    if (!m) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_bytes[a[11:0] + i] = wd[8*i +: 8];
        e.chk_rdata = 1'b0;
      end else begin
        v = ref_read(a[11:0], n);
        if (t == 3'd3 && v[7])  v = v | 32'hFFFF_FF00;
        if (t == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        e.rdata = v;
      end
    end
  endtask

  task automatic fetch_txn(input logic [31:0] a);
    exp_t e;
    int n = 0;
    e.mis = (a[1:0] != 0); e.bus = 1'b0; e.chk_rdata = 1'b1;
    e.rdata = e.mis ? 32'h0 : ref_read(a[11:0], 4);
    if_q.push_back(e);
    bus_if.if_addr = a;
    bus_if.if_req  = 1'b1;
    do begin @(negedge clk); n++; end while (!bus_if.if_ack && n < 60);
    if (!bus_if.if_ack) chk("if_ack_wait", 32'h0, 32'h1);
    @(posedge clk); #1;
    bus_if.if_req = 1'b0;
  endtask

  task automatic data_txn(input logic we, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] wd, input bit tmo,
                          output logic [31:0] rd, output int req_cycles);
    exp_t e;
    int n = 0;
    if (tmo) begin e.rdata = '0; e.chk_rdata = 1'b1; e.mis = 1'b0; e.bus = 1'b1; end
    else model_data(we, t, a, wd, e);
    d_q.push_back(e);
    bus_if.d_we = we; bus_if.d_type = t; bus_if.d_addr = a; bus_if.d_wdata = wd;
    bus_if.d_req = 1'b1;
    req_cycles = 0;
    do begin
      @(negedge clk); n++;
      if (bus_if.mem_req) req_cycles++;
    end while (!bus_if.d_ack && n < 60);
    if (!bus_if.d_ack) chk("d_ack_wait", 32'h0, 32'h1);
    rd = bus_if.d_rdata;
    @(posedge clk); #1;
    bus_if.d_req = 1'b0;
  endtask

  // Memory model: ready after a random number of wait cycles; writes land with the handshake.
  always @(negedge clk) begin
    if (bus_if.mem_req && !stuck) begin
      if (wait_cnt == 0) begin
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = mem_words[bus_if.mem_addr[11:2]];
        if (bus_if.mem_we)
          for (int k = 0; k < 4; k++)
            if (bus_if.mem_be[k]) mem_words[bus_if.mem_addr[11:2]][8*k +: 8] = bus_if.mem_wdata[8*k +: 8];
      end else begin
        wait_cnt--;
        bus_if.mem_ready = 1'b0;
        bus_if.mem_rdata = $urandom;
      end
    end else begin
      bus_if.mem_ready = 1'b0;
      bus_if.mem_rdata = $urandom;
      wait_cnt = $urandom_range(max_wait, 0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus_if.if_ack || bus_if.d_ack) chk("dual_ack", 32'(bus_if.if_ack & bus_if.d_ack), 32'h0);
    if (bus_if.if_ack) begin
      if (if_q.size() == 0) chk("if_spurious_ack", 32'h1, 32'h0);
      else begin
        e = if_q.pop_front();
        chk("if_rdata", bus_if.if_rdata, e.rdata);
        chk("if_misalign", 32'(bus_if.misalign_err), 32'(e.mis));
        chk("if_bus_err", 32'(bus_if.bus_err), 32'(e.bus));
      end
    end
    if (bus_if.d_ack) begin
      if (d_q.size() == 0) chk("d_spurious_ack", 32'h1, 32'h0);
      else begin
        e = d_q.pop_front();
        if (e.chk_rdata) chk("d_rdata", bus_if.d_rdata, e.rdata);
        chk("d_misalign", 32'(bus_if.misalign_err), 32'(e.mis));
        chk("d_bus_err", 32'(bus_if.bus_err), 32'(e.bus));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd_a, rd_b, addr;
    int rc_a, rc_b;

    rst = 1'b0;
    bus_if.if_req = 1'b0; bus_if.if_addr = '0;
    bus_if.d_req = 1'b0; bus_if.d_we = 1'b0; bus_if.d_type = '0;
    bus_if.d_addr = '0; bus_if.d_wdata = '0;
    bus_if.mem_ready = 1'b0; bus_if.mem_rdata = '0;
    for (int i = 0; i < 1024; i++) set_word(32'(i * 4), $urandom);

    repeat (2) @(posedge clk);
    #1 bus_if.if_req = 1'b1; bus_if.if_addr = 32'h10;
    @(negedge clk);
    chk("rst_mem_req", 32'(bus_if.mem_req), 32'h0);
    chk("rst_if_ack", 32'(bus_if.if_ack), 32'h0);
    chk("rst_if_stall", 32'(bus_if.if_stall), 32'h1);
    chk("rst_errs", {30'b0, bus_if.misalign_err, bus_if.bus_err}, 32'h0);
    @(posedge clk); #1;
    bus_if.if_req = 1'b0;
    rst = 1'b1;

    // Zero-wait fetch: ack on the third cycle.
    set_word(32'h10, 32'h0010_0093);
    fork
      fetch_txn(32'h10);
      begin
        @(negedge clk);
        chk("f1_c1_stall", 32'(bus_if.if_stall), 32'h1);
        chk("f1_c1_mem_req", 32'(bus_if.mem_req), 32'h0);
        @(negedge clk);
        chk("f1_c2_mem_req", 32'(bus_if.mem_req), 32'h1);
        chk("f1_c2_mem_addr", bus_if.mem_addr, 32'h10);
        chk("f1_c2_mem_be", 32'(bus_if.mem_be), 32'hF);
        chk("f1_c2_stall", 32'(bus_if.if_stall), 32'h1);
        @(negedge clk);
        chk("f1_c3_ack", 32'(bus_if.if_ack), 32'h1);
        chk("f1_c3_rdata", bus_if.if_rdata, 32'h0010_0093);
      end
    join

    // Simultaneous store byte and fetch, then data re-requests while fetch waits.
    fork
      fetch_txn(32'h20);
      begin
        data_txn(1'b1, 3'd3, 32'h103, 32'h1234_56AB, 1'b0, rd_a, rc_a);
        data_txn(1'b0, 3'd0, 32'h400, 32'h0, 1'b0, rd_b, rc_b);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        chk("p2_store_we", 32'(bus_if.mem_we), 32'h1);
        chk("p2_store_be", 32'(bus_if.mem_be), 32'h8);
        chk("p2_store_wdata", bus_if.mem_wdata, 32'hABAB_ABAB);
        chk("p2_store_addr", bus_if.mem_addr, 32'h100);
        @(negedge clk);
        chk("p2_data_first", 32'(bus_if.d_ack), 32'h1);
        repeat (2) @(negedge clk);
        chk("p2_fetch_second", bus_if.mem_addr, 32'h20);
        chk("p2_fetch_we", 32'(bus_if.mem_we), 32'h0);
        repeat (3) @(negedge clk);
        chk("p2_data_third", bus_if.mem_addr, 32'h400);
      end
    join

    // Load extension.
    set_word(32'h100, 32'h0080_0000);
    data_txn(1'b0, 3'd3, 32'h102, 32'h0, 1'b0, rd_a, rc_a);
    chk("lb_signed", rd_a, 32'hFFFF_FF80);
    data_txn(1'b0, 3'd4, 32'h102, 32'h0, 1'b0, rd_a, rc_a);
    chk("lbu", rd_a, 32'h0000_0080);
    set_word(32'h100, 32'h8001_0000);
    data_txn(1'b0, 3'd1, 32'h102, 32'h0, 1'b0, rd_a, rc_a);
    chk("lh_signed", rd_a, 32'hFFFF_8001);

    // Misaligned word load: no memory cycle, ack on cycle 2.
    fork
      data_txn(1'b0, 3'd0, 32'h6, 32'h0, 1'b0, rd_a, rc_a);
      begin
        @(negedge clk);
        chk("mis_c1_mem_req", 32'(bus_if.mem_req), 32'h0);
        chk("mis_c1_stall", 32'(bus_if.d_stall), 32'h1);
        @(negedge clk);
        chk("mis_c2_ack", 32'(bus_if.d_ack), 32'h1);
        chk("mis_c2_err", 32'(bus_if.misalign_err), 32'h1);
        chk("mis_c2_mem_req", 32'(bus_if.mem_req), 32'h0);
        chk("mis_c2_rdata", bus_if.d_rdata, 32'h0);
      end
    join

    // Timeout with memory never ready.
    stuck = 1'b1;
    data_txn(1'b0, 3'd0, 32'h400, 32'h0, 1'b1, rd_a, rc_a);
    chk("tmo_req_cycles", 32'(rc_a), 32'd4);
    stuck = 1'b0;
    @(negedge clk);
    chk("tmo_idle_mem_req", 32'(bus_if.mem_req), 32'h0);
    @(posedge clk); #1;

    // Reset in the middle of BUSY abandons the access.
    bus_if.d_we = 1'b0; bus_if.d_type = 3'd0; bus_if.d_addr = 32'h404; bus_if.d_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rstb_mem_req_before", 32'(bus_if.mem_req), 32'h1);
    rst = 1'b0;
    bus_if.d_req = 1'b0;
    @(negedge clk);
    chk("rstb_mem_req_after", 32'(bus_if.mem_req), 32'h0);
    chk("rstb_no_ack", {30'b0, bus_if.if_ack, bus_if.d_ack}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    data_txn(1'b0, 3'd0, 32'h404, 32'h0, 1'b0, rd_a, rc_a);
    chk("rstb_fresh_load", rd_a, ref_read(12'h404, 4));

    // Randomised concurrent traffic.
    max_wait = 2;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          addr = 32'($urandom_range(255, 0)) * 4;
          if ($urandom_range(9, 0) == 0) addr = addr + 32'($urandom_range(3, 1));
          fetch_txn(addr);
          repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          data_txn(1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)),
                   32'h400 + 32'($urandom_range(1023, 0)), $urandom, 1'b0, rd_b, rc_b);
          repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
        end
      end
    join

    repeat (4) @(negedge clk);
    chk("if_q_drained", 32'(if_q.size()), 32'h0);
    chk("d_q_drained", 32'(d_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch stage and its MEM stage (load/store).
- Arbitrates between the two requesters and sequences each access over a req/ready handshake.
- Generates byte enables and lane-aligned store data, and sign/zero-extends load data per DMType.
- Returns per-requester stall signals so the hazard logic can freeze PC, IF_ID and the later pipeline registers.

Parameters:
- TIMEOUT, 255: cycles to wait for mem_ready before aborting with bus_err. 0 disables the timeout.
- DATA_PRIO, 1: 1 = MEM stage wins simultaneous requests (anti-starvation rule still applies); 0 = strict alternation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr stable until if_ack.
- if_addr  in  32  fetch byte address; must be word aligned.
- if_rdata  out  32  fetched instruction; valid while if_ack=1.
- if_ack  out  1  one-cycle completion pulse for fetch.
- if_stall  out  1  if_req & ~if_ack (combinational).
- d_req  in  1  data request; held with d_we/d_type/d_addr/d_wdata stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_type  in  3  DMType code.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, right-aligned.
- d_rdata  out  32  extended load data; valid while d_ack=1.
- d_ack  out  1  one-cycle completion pulse for data.
- d_stall  out  1  d_req & ~d_ack (combinational).
- misalign_err  out  1  pulses with d_ack or if_ack when the access was misaligned.
- bus_err  out  1  pulses with the ack when the access timed out.
- mem_req  out  1  memory request; held until mem_ready is sampled high.
- mem_we  out  1  memory write.
- mem_addr  out  32  word address: {addr[31:2], 2'b00}.
- mem_be  out  4  byte enables; 4'b1111 for reads.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  memory read word; sampled when mem_ready=1.
- mem_ready  in  1  access complete (same role as MIO_ready).

Behaviour:
- Reset (rst=0 at the edge):
  - State goes to IDLE; last_grant=IF; timeout counter cleared.
  - All outputs 0 except if_stall/d_stall, which follow their equations.
  - A reset mid-access abandons it: mem_req drops the next cycle and no ack is issued.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any request is pending, grant, latch requester id, address, type and data, and go to BUSY.
  - Misaligned data or fetch requests go directly to RESP with misalign_err; no memory cycle is issued.
- Grant rule:
  - Only one requester pending: grant it.
  - Both pending with DATA_PRIO=1: data wins unless last_grant was data, in which case IF wins.
  - Both pending with DATA_PRIO=0: grant the requester opposite to last_grant.
  - last_grant updates on every grant.
- BUSY:
  - mem_req=1 with all mem_* driven from the latched values.
  - When mem_ready=1: capture mem_rdata, go to RESP.
  - When the counter reaches TIMEOUT (TIMEOUT≠0): go to RESP with bus_err and read data 0.
- RESP:
  - Exactly one ack is high for one cycle, plus any error flags; rdata outputs are registered.
  - Next state is IDLE. The requester updates or drops its req on this edge; IDLE samples the new value next cycle.
- Latency: minimum 3 cycles from req to ack (IDLE→BUSY→RESP) with zero-wait memory. Throughput is one access per 3 cycles.
- Alignment: word requires addr[1:0]=0; halfword requires addr[0]=0; byte is always aligned.
- Store lanes:
  - Byte: mem_be=4'b0001<<addr[1:0]; mem_wdata={4{wdata[7:0]}}.
  - Halfword: mem_be=4'b0011<<(2*addr[1]); mem_wdata={2{wdata[15:0]}}.
  - Word: mem_be=4'b1111.
- Load extraction:
  - Select the lane by addr[1:0] (byte) or addr[1] (halfword).
  - Sign-extend for byte/halfword, zero-extend for the unsigned variants.
  - Fetch data is returned raw.
- Unknown d_type is treated as word.
- mem_rdata and mem_ready are ignored outside BUSY.

Decomposition:
- DMType codes live in the shared ctrl_encode_def package: dm_word=0, dm_halfword=1, dm_halfword_unsigned=2, dm_byte=3, dm_byte_unsigned=4.
- FSM state encodings are defined in the same package.
- One sub-module is natural: mem_lane_align.
  - Purely combinational.
  - Inputs: type, addr[1:0], wdata, rdata.
  - Outputs: be, wdata_out, rdata_ext, misaligned.

Test Plan:
- Fetch only, if_addr=0x0000_0010, memory returns 0x0010_0093 with zero wait → mem_addr=0x10, mem_be=4'hF, if_ack on cycle 3 with if_rdata=0x0010_0093, if_stall high cycles 1–2.
- Simultaneous if_req and d_req store byte 0xAB at 0x103, DATA_PRIO=1 → data granted first with mem_be=4'b1000 and mem_wdata=0xABABABAB; fetch granted next; a second simultaneous pair is granted IF first (anti-starvation).
- Load byte signed from 0x102 with mem_rdata=0x0080_0000 → d_rdata=0xFFFF_FF80; unsigned variant → 0x0000_0080; halfword signed at 0x102 with mem_rdata=0x8001_0000 → 0xFFFF_8001.
- Word load at 0x0000_0006 → no mem_req, d_ack and misalign_err pulse together on cycle 2, d_rdata=0.
- TIMEOUT=4 with mem_ready held low → mem_req high exactly 4 cycles, then d_ack with bus_err, d_rdata=0, FSM returns to IDLE.
- rst low during BUSY → next cycle mem_req=0, no ack, state IDLE; a fresh request after release completes normally.
